// File: rtl/stb_from_utf8_stream_if.sv
// Call/return, byte-in and unit-out handshake bundle for stb_from_utf8_stream.
interface stb_from_utf8_stream_if #(
    parameter int unsigned OUT_W = 16,
    parameter int unsigned CNT_W = 32
);
    logic             start;
    logic             busy;
    logic [CNT_W-1:0] n;
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             done;
    logic             stall;
    logic [CNT_W-1:0] returndata;
    logic [1:0]       status;

    modport master (
        output start, n, in_data, in_valid, out_ready, stall,
        input  busy, in_ready, out_data, out_valid, done, returndata, status
    );

    modport slave (
        input  start, n, in_data, in_valid, out_ready, stall,
        output busy, in_ready, out_data, out_valid, done, returndata, status
    );
endinterface

// File: rtl/stb_from_utf8_stream.sv
// Streaming UTF-8 decoder producing UTF-16 (with surrogate pairs) or UTF-32
// code units followed by a NUL terminator; returns units written and a status.
module stb_from_utf8_stream #(
    parameter int unsigned OUT_W           = 16,
    parameter int unsigned CNT_W           = 32,
    parameter int unsigned REPLACE_INVALID = 0
) (
    input logic                   clock,
    input logic                   reset,
    stb_from_utf8_stream_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_CONT,
        S_EMIT,
        S_EMIT_LO,
        S_TERM,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [20:0]      cp_q, cp_d;
    logic [1:0]       need_q, need_d;    // continuation bytes still expected
    logic [1:0]       extra_q, extra_d;  // continuation bytes in this sequence
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [1:0]       status_q, status_d;

    logic             cont_byte;
    logic             k2;
    logic             fits;
    logic [CNT_W:0]   cnt_plus_k;
    logic [CNT_W:0]   limit;
    logic [20:0]      cp_shift;
    logic             range_ok;
    logic [9:0]       hi10;
    logic [OUT_W-1:0] unit_main;
    logic [OUT_W-1:0] unit_lo;

    logic             in_rdy;
    logic             out_vld;
    logic             in_fire;
    logic             out_fire;
    logic             bad;

    // Shared decode helpers: continuation test, capacity check, surrogate split.
    always_comb begin
        cont_byte  = (bus.in_data[7:6] == 2'b10);
        k2         = (OUT_W == 16) && (cp_q[20:16] != 5'd0);
        cnt_plus_k = {1'b0, count_q} + (k2 ? (CNT_W+1)'(2) : (CNT_W+1)'(1));
        limit      = {1'b0, n_q} - (CNT_W+1)'(1);
        fits       = (cnt_plus_k <= limit);
        cp_shift   = {cp_q[14:0], bus.in_data[5:0]};
        unique case (extra_q)
            2'd2:    range_ok = (cp_shift >= 21'h000800) &&
                                !((cp_shift >= 21'h00D800) && (cp_shift <= 21'h00DFFF));
            2'd3:    range_ok = (cp_shift >= 21'h010000) && (cp_shift <= 21'h10FFFF);
            default: range_ok = 1'b1;
        endcase
        // (cp - 0x10000) >> 10 only needs the low 10 bits of (cp >> 10) - 0x40
        hi10      = cp_q[19:10] - 10'd64;
        unit_main = k2 ? OUT_W'({6'b110110, hi10}) : OUT_W'(cp_q);
        unit_lo   = OUT_W'({6'b110111, cp_q[9:0]});
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cp_q     <= '0;
            need_q   <= '0;
            extra_q  <= '0;
            count_q  <= '0;
            n_q      <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            cp_q     <= cp_d;
            need_q   <= need_d;
            extra_q  <= extra_d;
            count_q  <= count_d;
            n_q      <= n_d;
            status_q <= status_d;
        end
    end

    // Next-state and datapath update for each accepted byte or emitted unit.
    always_comb begin
        state_d  = state_q;
        cp_d     = cp_q;
        need_d   = need_q;
        extra_d  = extra_q;
        count_d  = count_q;
        n_d      = n_q;
        status_d = status_q;
        bad      = 1'b0;
        in_fire  = bus.in_valid && in_rdy;
        out_fire = out_vld && bus.out_ready;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    n_d      = bus.n;
                    count_d  = '0;
                    status_d = 2'd0;
                    if (bus.n == '0) begin
                        status_d = 2'd2;
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_LEAD;
                    end
                end
            end
            S_LEAD: begin
                if (in_fire) begin
                    if (bus.in_data == 8'h00) begin
                        state_d = S_TERM;
                    end else if (bus.in_data < 8'h80) begin
                        cp_d    = 21'(bus.in_data);
                        state_d = S_EMIT;
                    end else if (bus.in_data >= 8'hC2 && bus.in_data <= 8'hDF) begin
                        cp_d    = 21'(bus.in_data[4:0]);
                        need_d  = 2'd1;
                        extra_d = 2'd1;
                        state_d = S_CONT;
                    end else if (bus.in_data >= 8'hE0 && bus.in_data <= 8'hEF) begin
                        cp_d    = 21'(bus.in_data[3:0]);
                        need_d  = 2'd2;
                        extra_d = 2'd2;
                        state_d = S_CONT;
                    end else if (bus.in_data >= 8'hF0 && bus.in_data <= 8'hF4) begin
                        cp_d    = 21'(bus.in_data[2:0]);
                        need_d  = 2'd3;
                        extra_d = 2'd3;
                        state_d = S_CONT;
                    end else begin
                        bad = 1'b1;
                    end
                end
            end
            S_CONT: begin
                if (bus.in_valid) begin
                    if (cont_byte) begin
                        cp_d   = cp_shift;
                        need_d = need_q - 2'd1;
                        if (need_q == 2'd1) begin
                            if (range_ok) begin
                                state_d = S_EMIT;
                            end else begin
                                bad = 1'b1;
                            end
                        end
                    end else begin
                        // in_ready is low for this byte, so it stays at the
                        // head of the stream and is re-decoded from LEAD.
                        bad = 1'b1;
                    end
                end
            end
            S_EMIT: begin
                if (!fits) begin
                    status_d = 2'd2;
                    state_d  = S_DONE;
                end else if (out_fire) begin
                    count_d = count_q + CNT_W'(1);
                    state_d = k2 ? S_EMIT_LO : S_LEAD;
                end
            end
            S_EMIT_LO: begin
                if (out_fire) begin
                    count_d = count_q + CNT_W'(1);
                    state_d = S_LEAD;
                end
            end
            S_TERM: begin
                if (out_fire) begin
                    status_d = 2'd0;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (!bus.stall) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (bad) begin
            if (REPLACE_INVALID != 0) begin
                cp_d    = 21'h00FFFD;
                state_d = S_EMIT;
            end else begin
                status_d = 2'd1;
                state_d  = S_DONE;
            end
        end
    end

    // Handshake and return outputs decoded from the current state.
    always_comb begin
        in_rdy  = 1'b0;
        out_vld = 1'b0;
        bus.out_data = '0;
        unique case (state_q)
            S_LEAD:    in_rdy = 1'b1;
            S_CONT:    in_rdy = !bus.in_valid || cont_byte;
            S_EMIT: begin
                out_vld      = fits;
                bus.out_data = unit_main;
            end
            S_EMIT_LO: begin
                out_vld      = 1'b1;
                bus.out_data = unit_lo;
            end
            S_TERM:    out_vld = 1'b1;
            default: begin
                in_rdy  = 1'b0;
                out_vld = 1'b0;
            end
        endcase
        bus.in_ready   = in_rdy;
        bus.out_valid  = out_vld;
        bus.busy       = (state_q != S_IDLE);
        bus.done       = (state_q == S_DONE);
        bus.returndata = count_q;
        bus.status     = status_q;
    end

endmodule
